x_burst_gen: RTL
================

// Module: x_burst_gen
// PURPOSE
//  Source side of the x/count handshake: generates the x stream that the counting
//    control unit consumes.
//  On a start request it latches a burst length L and drives x high for exactly
//    L consecutive cycles.
//  It then holds x low for a guard interval and pulses done for one cycle.
//  Sits upstream of the counting unit; done/busy go to the sequencing logic.
// PARAMETERS
//  W    4  width of burst length and internal down-counter (max burst 2^W-1)
//  GAP  2  guard cycles with x low between end of burst and done (0 = no guard)
// PORTS
//  clk    in   1  single clock, all state updates on posedge
//  reset  in   1  asynchronous, active-low; 0 forces reset state immediately
//  s      in   1  start request, sampled only in IDLE
//  len    in   W  burst length L, latched on the edge that accepts s
//  abort  in   1  synchronous cancel, effective in any non-IDLE state
//  x      out  1  burst output, Moore-decoded from registered state (glitch-free)
//  busy   out  1  1 whenever state != IDLE
//  done   out  1  one-cycle pulse on normal completion; never asserted after abort
// BEHAVIOUR
//  Reset values: state=IDLE, cnt=0, gcnt=0, x=0, busy=0, done=0.
//    Reset low mid-burst drops x the same instant; no done follows.
//  States and transitions:
//    IDLE -> SEND when s=1 and len!=0: cnt<=len.
//    IDLE -> DONE when s=1 and len==0: zero-length burst, x never rises.
//    SEND: x=1, cnt decrements each cycle.
//      cnt==1 -> GAP, or -> DONE when GAP==0.
//    GAP: x=0, gcnt counts 0..GAP-1; gcnt==GAP-1 -> DONE.
//    DONE: done=1 for one cycle -> IDLE.
//  Latency: s accepted at edge k -> x=1 in the cycles after edges k..k+L-1.
//    Counting the cycle after edge k as cycle 1, x is high in cycles 1..L,
//    low from cycle L+1.
//    done is high in cycle L+GAP+1 (for L=0: cycle 1).
//  s while busy: ignored, not queued.
//    s held high continuously: a new burst starts on the edge leaving DONE->IDLE+1,
//    i.e. IDLE is visited for >=1 cycle between bursts.
//  len sampled only on the accepting edge; later changes have no effect on the
//    running burst.
//  abort=1 in SEND/GAP/DONE: next state IDLE, x=0 next cycle, done suppressed.
//    abort has priority over every other transition.
//    abort in IDLE has no effect and does not block s.
//  Arithmetic: cnt is W-bit unsigned, never wraps (exit at 1, load only non-zero).
//    gcnt width is clog2(GAP), min 1 bit.
//  Outputs busy/done/x are pure decodes of registered state; no combinational
//    path from s/len/abort to any output.
// STRUCTURE
//  Shared package: state encoding constants (ST_IDLE, ST_SEND, ST_GAP, ST_DONE,
//    2-bit) shared with the counting control unit's bench models.
//  Sub-module: burst_down_counter (W-bit loadable down-counter: load, dec, zero_one
//    flag, async active-low clear), instantiated once for cnt.
//  FSM next-state logic and gcnt live in x_burst_gen.
// TESTING
//  1 reset low 3 cycles then high, s=0 -> x=0, busy=0, done=0 throughout.
//  2 s=1 one cycle, len=5, GAP=2 -> x high exactly 5 cycles; done pulse exactly 3
//    cycles after x falls; busy high 8 cycles.
//  3 len=0, s=1 -> x stays 0; done=1 in the next cycle; busy 1 cycle.
//  4 len=15 -> 15 x-high cycles; feeding x to the counting unit yields its count
//    = 15 and g=1.
//  5 abort on the 3rd SEND cycle of a len=9 burst -> x low next cycle, no done,
//    busy=0; an s one cycle later starts a fresh burst.
//  6 s held high, len=4 -> bursts of 4 separated by GAP+2 low cycles; reset low
//    mid-burst -> x=0 immediately, no done.

Source files
------------

// File: rtl/x_burst_gen_pkg.sv
// Shared state encoding for the x burst source and the counting unit's models.
// Also hosts the guard-counter width helper so bench models size gcnt identically.
package x_burst_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Guard counter needs at least one bit even when GAP is 0 or 1.
    function automatic int gcnt_width(input int gap);
        return (gap > 1) ? $clog2(gap) : 1;
    endfunction

endpackage

// File: rtl/x_burst_gen_if.sv
// Start/length/abort request and x/busy/done response bundle of the burst source.
// master drives requests (sequencer side); slave is the burst generator.
interface x_burst_gen_if #(
    parameter int W = 4
);
    logic         s;
    logic [W-1:0] len;
    logic         abort;
    logic         x;
    logic         busy;
    logic         done;

    modport master (output s, len, abort, input x, busy, done);
    modport slave  (input s, len, abort, output x, busy, done);
endinterface

// File: rtl/x_burst_gen_burst_down_counter.sv
// W-bit loadable down-counter; load wins over dec, zero_one flags cnt == 1.
// Latency: one cycle from load/dec to cnt; no backpressure.
module burst_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero_one
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec)
            cnt <= cnt - W'(1);
    end

    assign zero_one = (cnt == W'(1));

endmodule

// File: rtl/x_burst_gen.sv
// Burst source: on accepted s drives x high for len cycles, then GAP low cycles, then a done pulse.
// Latency: x rises the cycle after s is accepted; s ignored while busy; abort returns to IDLE next cycle.
module x_burst_gen
    import x_burst_gen_pkg::*;
#(
    parameter int W   = 4,
    parameter int GAP = 2
) (
    input  logic           clk,
    input  logic           reset,
    x_burst_gen_if.slave   bus
);

    localparam int GW = gcnt_width(GAP);
    localparam logic [GW-1:0] GLAST = GW'((GAP > 0) ? GAP - 1 : 0);

    state_e         state, next;
    logic [GW-1:0]  gcnt;
    logic [W-1:0]   cnt;
    logic           cnt_last;
    logic           cnt_load;
    logic           x_o, busy_o, done_o;

    assign cnt_load = (state == ST_IDLE) && bus.s && (bus.len != '0);

    burst_down_counter #(.W(W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (state == ST_SEND),
        .load_val (bus.len),
        .cnt      (cnt),
        .zero_one (cnt_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= next;
    end

    // gcnt restarts from 0 on every entry into GAP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            gcnt <= '0;
        else if (state == ST_GAP && next == ST_GAP)
            gcnt <= gcnt + GW'(1);
        else
            gcnt <= '0;
    end

    always_comb begin
        next   = state;
        x_o    = 1'b0;
        busy_o = (state != ST_IDLE);
        done_o = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.s)
                    next = (bus.len != '0) ? ST_SEND : ST_DONE;
            end
            ST_SEND: begin
                x_o = 1'b1;
                if (cnt_last)
                    next = (GAP == 0) ? ST_DONE : ST_GAP;
            end
            ST_GAP: begin
                if (gcnt == GLAST)
                    next = ST_DONE;
            end
            ST_DONE: begin
                done_o = 1'b1;
                next   = ST_IDLE;
            end
            default: next = ST_IDLE;
        endcase
        // Cancel overrides every other transition, including the done exit.
        if (bus.abort && state != ST_IDLE)
            next = ST_IDLE;
    end

    assign bus.x    = x_o;
    assign bus.busy = busy_o;
    assign bus.done = done_o;

    logic unused_cnt;
    assign unused_cnt = ^cnt;

endmodule
